// File: rtl/triage_intake.sv
// ---------------------------------------------------------------------------
// triage_intake
//
// Intake stage in front of the patient priority queue. Arrivals carrying a
// 3-bit severity are buffered in a small in-order FIFO. Each FIFO head is
// given the lowest-numbered free ID from a 4-entry pool. The resulting
// {priority, id} word is then offered to the queue with a valid/ready
// handshake. An ID goes back to the pool when the patient is discharged, so
// at most 4 patients are ever in the system.
//
// Parameters
//   DEPTH      arrival FIFO entries (power of two, 2..16)
//   AGE_LIMIT  cycles resident in the FIFO before an entry's priority bumps
//              (used only when TRIAGE_AGING_EN is defined; 1..255)
//
// Optional feature macro
//   TRIAGE_AGING_EN  when defined, each FIFO entry carries an 8-bit age
//                    counter. Every AGE_LIMIT resident cycles the entry's
//                    priority goes up by one, saturating at 3.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst_n         synchronous active-low reset
//   arr_valid     arrival request
//   arr_severity  arrival severity 0..7 (priority = severity[2:1])
//   arr_ready     FIFO can accept; arrival taken on arr_valid & arr_ready
//   disch_valid   discharge strobe
//   disch_id      ID being discharged
//   disch_err     one-cycle pulse: discharge of an ID that was not allocated
//   enq_valid     enq_data valid toward the queue
//   enq_ready     queue accepts this cycle
//   enq_data      [3:2] priority (3 = most urgent), [1:0] patient ID
//   free_cnt      number of free IDs, 0..4
//   pending       number of entries in the FIFO
// ---------------------------------------------------------------------------
module triage_intake #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AGE_LIMIT = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           arr_valid,
  input  logic [2:0]                     arr_severity,
  output logic                           arr_ready,
  input  logic                           disch_valid,
  input  logic [1:0]                     disch_id,
  output logic                           disch_err,
  output logic                           enq_valid,
  input  logic                           enq_ready,
  output logic [3:0]                     enq_data,
  output logic [2:0]                     free_cnt,
  output logic [$clog2(DEPTH+1)-1:0]     pending
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("triage_intake: DEPTH must be a power of two in 2..16");
  end
  if (AGE_LIMIT < 1 || AGE_LIMIT > 255) begin : g_bad_age
    $error("triage_intake: AGE_LIMIT must be in 1..255");
  end

  typedef enum logic {
    IDLE,
    OFFER
  } state_t;

  state_t          state;

  logic [1:0]      prio_mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [3:0]      free_mask;
  logic [3:0]      mask_next;
  logic [1:0]      alloc_id;
  logic            push;
  logic            pop;
  logic            disch_hit;
  logic            disch_bad;

  // Only severity[2:1] feeds the priority map.
  logic            unused_sev_lsb;
  assign unused_sev_lsb = arr_severity[0];

  // ---------------------------------------------------------------------
  // Handshake and pool bookkeeping
  // ---------------------------------------------------------------------
  // The registered count is used here, so a pop in the same cycle does not
  // free a slot for a push into a full FIFO.
  assign arr_ready = rst_n & (count != CW'(DEPTH));
  assign push      = arr_valid & arr_ready;
  assign pop       = (state == IDLE) && (count != '0) && (free_mask != '0);
  assign pending   = count;

  assign disch_hit = disch_valid & ~free_mask[disch_id];
  assign disch_bad = disch_valid &  free_mask[disch_id];

  always_comb begin
    alloc_id = 2'd0;
    if (free_mask[0])      alloc_id = 2'd0;
    else if (free_mask[1]) alloc_id = 2'd1;
    else if (free_mask[2]) alloc_id = 2'd2;
    else if (free_mask[3]) alloc_id = 2'd3;
  end

  always_comb begin
    free_cnt = 3'(free_mask[0]) + 3'(free_mask[1])
             + 3'(free_mask[2]) + 3'(free_mask[3]);
  end

  // Allocation picks from the pre-edge mask. An ID freed in the same cycle
  // only becomes available from the next edge. A discharge can never target
  // the ID being allocated, because that bit is still set pre-edge and the
  // discharge is flagged as an error instead.
  always_comb begin
    mask_next = free_mask;
    if (disch_hit) mask_next[disch_id] = 1'b1;
    if (pop)       mask_next[alloc_id] = 1'b0;
  end

  // ---------------------------------------------------------------------
  // FIFO pointers, occupancy, ID pool, discharge error pulse
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      free_mask <= '1;
      disch_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      free_mask <= mask_next;
      disch_err <= disch_bad;
    end
  end

  // ---------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------
`ifdef TRIAGE_AGING_EN
  localparam logic [7:0] AGE_WRAP = 8'(AGE_LIMIT - 1);

  logic [7:0] age_mem [DEPTH];

  // Every slot ages every cycle. Stale slots outside the occupied window
  // are harmless, because a push zeroes the slot's age and rewrites its
  // priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        age_mem[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr == PW'(i))) begin
          prio_mem[i] <= arr_severity[2:1];
          age_mem[i]  <= '0;
        end else if (age_mem[i] == AGE_WRAP) begin
          age_mem[i] <= '0;
          if (prio_mem[i] != 2'd3) prio_mem[i] <= prio_mem[i] + 2'd1;
        end else begin
          age_mem[i] <= age_mem[i] + 8'd1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (push) prio_mem[wr_ptr] <= arr_severity[2:1];
  end
`endif

  // ---------------------------------------------------------------------
  // Offer FSM. enq_valid and enq_data are registered. The word stays stable
  // throughout OFFER. Going back through IDLE enforces at least one gap
  // cycle between offered words.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      enq_valid <= 1'b0;
      enq_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            enq_data  <= {prio_mem[rd_ptr], alloc_id};
            enq_valid <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (enq_ready) begin
            enq_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          enq_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
